// File: rtl/uart_tx_fsm.sv
// UART transmitter control FSM: start, data, optional parity, stop sequencing.
// Optional UART_TX_BACK_TO_BACK_EN lets STOP chain straight into the next START.
module uart_tx_fsm #(
    parameter int SEL_WIDTH = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Data_Valid,
    input  logic                 ser_done,
    input  logic                 parity_enable,
    output logic                 Enable,
    output logic [SEL_WIDTH-1:0] mux_SEL,
    output logic                 Busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [1:0] SEL_START = 2'd0;
    localparam logic [1:0] SEL_IDLE  = 2'd1;
    localparam logic [1:0] SEL_DATA  = 2'd2;
    localparam logic [1:0] SEL_PAR   = 2'd3;

    state_t     state_q, state_d;
    logic       enable_q, enable_d;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = Data_Valid ? S_START : S_IDLE;
            S_START:  state_d = S_DATA;
            S_DATA: begin
                if (!ser_done)
                    state_d = S_DATA;
                else if (parity_enable)
                    state_d = S_PARITY;
                else
                    state_d = S_STOP;
            end
            S_PARITY: state_d = S_STOP;
`ifdef UART_TX_BACK_TO_BACK_EN
            S_STOP:   state_d = Data_Valid ? S_START : S_IDLE;
`else
            S_STOP:   state_d = S_IDLE;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decode the next state so they register on the same edge.
    always_comb begin
        enable_d = 1'b0;
        sel_d    = SEL_IDLE;
        busy_d   = 1'b0;
        case (state_d)
            S_START: begin
                sel_d  = SEL_START;
                busy_d = 1'b1;
            end
            S_DATA: begin
                enable_d = 1'b1;
                sel_d    = SEL_DATA;
                busy_d   = 1'b1;
            end
            S_PARITY: begin
                sel_d  = SEL_PAR;
                busy_d = 1'b1;
            end
            S_STOP: begin
                sel_d  = SEL_IDLE;
                busy_d = 1'b1;
            end
            default: begin
                enable_d = 1'b0;
                sel_d    = SEL_IDLE;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            enable_q <= 1'b0;
            sel_q    <= SEL_IDLE;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
        end
    end

    assign Enable  = enable_q;
    assign mux_SEL = SEL_WIDTH'(sel_q);
    assign Busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Scoreboard bench for uart_tx_fsm: directed steps push expectations,
// a monitor pops and compares after each clock edge or reset assertion.
module tb_uart_tx_fsm;

    localparam int SW = 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic          Data_Valid;
    logic          ser_done;
    logic          parity_enable;
    logic          Enable;
    logic [SW-1:0] mux_SEL;
    logic          Busy;

    typedef struct packed {
        logic          en;
        logic [SW-1:0] sel;
        logic          busy;
        int unsigned   id;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;
    int   step_id = 0;

    uart_tx_fsm #(.SEL_WIDTH(SW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Data_Valid   (Data_Valid),
        .ser_done     (ser_done),
        .parity_enable(parity_enable),
        .Enable       (Enable),
        .mux_SEL      (mux_SEL),
        .Busy         (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic push_exp(input logic en, input logic [SW-1:0] sel,
                            input logic busy);
        exp_t e;
        e.en   = en;
        e.sel  = sel;
        e.busy = busy;
        e.id   = step_id;
        exp_q.push_back(e);
        step_id++;
    endtask

    // Drive inputs at the falling edge; expectation is for the next rising edge.
    task automatic step(input logic rst, input logic dv, input logic sd,
                        input logic pe, input logic en,
                        input logic [SW-1:0] sel, input logic busy);
        @(negedge CLK);
        RST           = rst;
        Data_Valid    = dv;
        ser_done      = sd;
        parity_enable = pe;
        push_exp(en, sel, busy);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK or posedge RST);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (Enable === e.en && mux_SEL === e.sel && Busy === e.busy)
                    passed++;
                else
                    $display("FAIL step%0d en/sel/busy got %b/%0d/%b want %b/%0d/%b",
                             e.id, Enable, mux_SEL, Busy, e.en, e.sel, e.busy);
            end
        end
    end

    initial begin : stim
        RST           = 1'b1;
        Data_Valid    = 1'b0;
        ser_done      = 1'b0;
        parity_enable = 1'b0;

        // reset state held across an edge
        step(1, 0, 0, 0, 0, 1, 0);
        // idle ignores ser_done and parity_enable
        step(0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 1, 0);
        // parity frame
        step(0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 1, 1, 1, 2, 1);
        for (int i = 0; i < 8; i++)
            step(0, 1, 0, 1, 1, 2, 1);
        step(0, 0, 1, 1, 0, 3, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        // no-parity frame
        step(0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 2, 1);
        step(0, 0, 0, 1, 1, 2, 1);
        step(0, 0, 1, 0, 0, 1, 1);
`ifdef UART_TX_BACK_TO_BACK_EN
        step(0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 2, 1);
`else
        step(0, 1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 2, 1);
`endif
        step(0, 0, 0, 0, 1, 2, 1);

        // asynchronous abort mid-DATA, between edges
        @(negedge CLK);
        #2;
        push_exp(0, 1, 0);
        RST = 1'b1;
        step(1, 1, 1, 1, 0, 1, 0);
        // clean frame after release
        step(0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 2, 1);
        step(0, 0, 1, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++)
            @(posedge CLK);
        #2;
        if (exp_q.size() > 0) begin
            total += exp_q.size();
            $display("FAIL drain %0d expectations left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
